if_fetch_controller: RTL
========================

Name: if_fetch_controller

Overview:
- Sequences the IF stage of the 16-bit pipelined CPU: owns the PC register and picks the next PC each cycle.
- Next-PC sources: sequential increment, the same-cycle jump decode (TakeJump/JumpAddress/Halt from the IF jump logic on the fetched instruction), EX-stage branch redirects, and hazard-unit stalls.
- Runs a halt/drain/resume state machine so older in-flight instructions retire before Halted is asserted.

Parameters:
- RegWidth, 16, PC and address width.
- ResetPC, 0, PC value loaded on reset.
- DrainCycles, 4, cycles spent in DRAIN after a halt is fetched (IF/ID through WB).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Stall  input  1  hazard unit: hold PC and the IF/ID register.
- BranchTaken  input  1  EX stage resolved a taken branch.
- BranchTarget  input  RegWidth  redirect address, valid with BranchTaken.
- TakeJump  input  1  jump logic: current instruction is a jump.
- JumpAddress  input  RegWidth  jump logic target.
- Halt  input  1  jump logic: current instruction is halt.
- Resume  input  1  external restart pulse, honoured only in HALTED.
- PC  output  RegWidth  current fetch address.
- FetchValid  output  1  instruction at PC is to be latched into IF/ID as valid.
- FlushIF  output  1  squash IF/ID and ID/EX this cycle.
- Halted  output  1  processor fully halted.

Behaviour:
- Single clock Clock. Reset is synchronous, active-high, and takes priority over all other inputs.
- Reset values: PC=ResetPC, state=RUN, drain counter=0, Halted=0. FetchValid and FlushIF are combinational, and during reset they evaluate to 0.
- States: RUN, DRAIN, HALTED. Halted is registered and equals (state==HALTED).
- The next-PC priority below is evaluated every cycle, first match wins.
- 1) BranchTaken, in any state: PC<=BranchTarget, FlushIF=1, FetchValid=0, state<=RUN, counter cleared.
  - This overrides Stall, Halt and TakeJump.
  - In DRAIN, a branch from an older instruction cancels the halt.
  - In HALTED, BranchTaken is ignored because the pipeline is empty.
- 2) RUN and Stall: PC held, FetchValid=0, no state change. Halt and TakeJump are ignored this cycle; they are re-evaluated when the stall releases.
- 3) RUN and Halt: PC held (not incremented), FetchValid=1 so the halt flows down the pipe, state<=DRAIN, counter<=DrainCycles-1.
- 4) RUN and TakeJump: PC<=JumpAddress, FetchValid=1, zero-bubble jump with no flush.
- 5) RUN, otherwise: PC<=PC+1, modulo 2^RegWidth. 0xFFFF wraps to 0x0000 with no flag.
- DRAIN:
  - FetchValid=0, PC held.
  - Counter decrements each cycle; Stall freezes it.
  - When counter==0 and no BranchTaken: state<=HALTED.
- HALTED:
  - PC holds the halt instruction's address; FetchValid=0.
  - Resume: PC<=PC+1, state<=RUN, Halted deasserts the next cycle.
  - Resume outside HALTED is ignored.
- Resume and Reset in the same cycle: Reset wins.
- Reset asserted mid-DRAIN or in HALTED returns to RUN at ResetPC.
- Halt and TakeJump together: never legal. Halt takes priority per the order above.
- FlushIF and FetchValid are never both 1.

Decomposition:
- Shared CPU package holds:
  - State encoding: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - RegWidth default.
  - ResetPC constant.
- Natural sub-module: pc_select_mux, the combinational priority next-PC selector. The FSM, drain counter and PC register stay in if_fetch_controller.
- The top-level testbench wires this block to the existing jump logic to check integration.

Test Plan:
- Reset=1 for 2 cycles with ResetPC=0, then release with no events -> PC reads 0,1,2,3 on successive cycles; FetchValid=1; Halted=0.
- At PC=8, TakeJump=1 with JumpAddress=0x0039 -> next PC=0x0039; FetchValid=1 both cycles; FlushIF never asserted.
- At PC=5, Stall=1 for 3 cycles with TakeJump=1 during the stall -> PC stays 5 and FetchValid=0 throughout. Stall releases with TakeJump=1 and JumpAddress=0x0020 -> PC=0x0020.
- At PC=0x10, Halt=1 -> FetchValid=1 for that cycle, then PC holds 0x10 for DrainCycles=4 cycles, then Halted=1. Resume pulse -> PC=0x11 and Halted=0 the next cycle.
- Halt at PC=0x10, then BranchTaken=1 with BranchTarget=0x0040 on DRAIN cycle 2 -> FlushIF=1, PC=0x0040, state RUN, Halted never asserts.
- PC=0xFFFF with a normal instruction -> PC=0x0000. Same cycle BranchTaken=1 and Stall=1 with BranchTarget=0x0100 -> PC=0x0100 (branch beats stall). Reset asserted in HALTED -> PC=0, Halted=0.

Source files
------------

// File: rtl/if_fetch_controller_pkg.sv
// Shared definitions for the IF-stage fetch controller: widths, reset PC,
// FSM state encoding and the next-PC source selector.
package if_fetch_controller_pkg;

    localparam int          REG_WIDTH    = 16;
    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam int          DRAIN_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_HALT   = 3'd3,
        SEL_BRANCH = 3'd4,
        SEL_RESUME = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/if_fetch_controller_pc_select_mux.sv
// Combinational next-PC priority selector: branch redirect, stall, halt,
// jump, increment, and resume out of HALTED.
module pc_select_mux
    import if_fetch_controller_pkg::*;
#(
    parameter int RegWidth = REG_WIDTH
) (
    input  fetch_state_e          i_state,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [RegWidth-1:0]   i_branch_target,
    input  logic                  i_take_jump,
    input  logic [RegWidth-1:0]   i_jump_address,
    input  logic                  i_halt,
    input  logic                  i_resume,
    input  logic [RegWidth-1:0]   i_pc,
    output logic [RegWidth-1:0]   o_next_pc,
    output logic                  o_fetch_valid,
    output logic                  o_flush,
    output pc_sel_e               o_sel
);

    logic [RegWidth-1:0] w_pc_inc;

    assign w_pc_inc = i_pc + RegWidth'(1);

    always_comb begin
        o_next_pc     = i_pc;
        o_fetch_valid = 1'b0;
        o_flush       = 1'b0;
        o_sel         = SEL_HOLD;

        // The pipeline is empty once HALTED, so a stray branch there is ignored.
        if (i_branch_taken && (i_state != ST_HALTED)) begin
            o_next_pc = i_branch_target;
            o_flush   = 1'b1;
            o_sel     = SEL_BRANCH;
        end else begin
            case (i_state)
                ST_RUN: begin
                    if (i_stall) begin
                        o_sel = SEL_HOLD;
                    end else if (i_halt) begin
                        o_fetch_valid = 1'b1;
                        o_sel         = SEL_HALT;
                    end else if (i_take_jump) begin
                        o_next_pc     = i_jump_address;
                        o_fetch_valid = 1'b1;
                        o_sel         = SEL_JUMP;
                    end else begin
                        o_next_pc     = w_pc_inc;
                        o_fetch_valid = 1'b1;
                        o_sel         = SEL_INC;
                    end
                end
                ST_HALTED: begin
                    if (i_resume) begin
                        o_next_pc = w_pc_inc;
                        o_sel     = SEL_RESUME;
                    end
                end
                default: begin
                    o_sel = SEL_HOLD;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_controller.sv
// IF-stage fetch controller: owns the PC register and the halt/drain/resume
// sequencing so older instructions retire before Halted is raised.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_RUN    | normal fetch: increment, jump, stall or take a halt
//   ST_DRAIN  | halt fetched; PC frozen while older instructions retire
//   ST_HALTED | pipeline empty; wait for Resume
module if_fetch_controller
    import if_fetch_controller_pkg::*;
#(
    parameter int                  RegWidth    = REG_WIDTH,
    parameter logic [RegWidth-1:0] ResetPC     = RegWidth'(RESET_PC),
    parameter int                  DrainCycles = DRAIN_CYCLES
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [RegWidth-1:0]   i_branch_target,
    input  logic                  i_take_jump,
    input  logic [RegWidth-1:0]   i_jump_address,
    input  logic                  i_halt,
    input  logic                  i_resume,
    output logic [RegWidth-1:0]   o_pc,
    output logic                  o_fetch_valid,
    output logic                  o_flush_if,
    output logic                  o_halted
);

    localparam int                CntW      = (DrainCycles > 2) ? $clog2(DrainCycles) : 1;
    localparam logic [CntW-1:0]   DrainLoad = CntW'(DrainCycles - 1);

    logic [RegWidth-1:0] r_pc;
    fetch_state_e        r_state;
    logic [CntW-1:0]     r_cnt;
    logic                r_halted;

    fetch_state_e        w_state_next;
    logic [CntW-1:0]     w_cnt_next;
    logic [RegWidth-1:0] w_next_pc;
    logic                w_fetch_valid;
    logic                w_flush;
    pc_sel_e             w_sel;

    pc_select_mux #(
        .RegWidth (RegWidth)
    ) u_pc_select_mux (
        .i_state         (r_state),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_take_jump     (i_take_jump),
        .i_jump_address  (i_jump_address),
        .i_halt          (i_halt),
        .i_resume        (i_resume),
        .i_pc            (r_pc),
        .o_next_pc       (w_next_pc),
        .o_fetch_valid   (w_fetch_valid),
        .o_flush         (w_flush),
        .o_sel           (w_sel)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc     <= ResetPC;
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_next_pc;
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_halted <= (w_state_next == ST_HALTED);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (w_sel)
            SEL_BRANCH: begin
                w_state_next = ST_RUN;
                w_cnt_next   = '0;
            end
            SEL_HALT: begin
                w_state_next = ST_DRAIN;
                w_cnt_next   = DrainLoad;
            end
            SEL_RESUME: begin
                w_state_next = ST_RUN;
            end
            default: begin
                // A stall holds the whole drain, including the final step to HALTED.
                if ((r_state == ST_DRAIN) && !i_stall) begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_HALTED;
                    end else begin
                        w_cnt_next = r_cnt - CntW'(1);
                    end
                end
            end
        endcase
    end

    assign o_pc          = r_pc;
    assign o_fetch_valid = w_fetch_valid & ~i_reset;
    assign o_flush_if    = w_flush & ~i_reset;
    assign o_halted      = r_halted;

endmodule
